alu_writeback_unit: RTL
=======================

ALU_WRITEBACK_UNIT -- requirements
Module: alu_writeback_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data width of operands, result and write-back data.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports as listed below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit can accept an operation this cycle.
REQ-007 opcode  input  3  operation select (REQ-012).
REQ-008 rs1_data  input  WIDTH  operand A, driven from register-bank read port 1.
REQ-009 rs2_data  input  WIDTH  operand B, driven from register-bank read port 2.
REQ-010 rd  input  2  destination register address.
REQ-011 wb_en, wb_reg[1:0], wb_data[WIDTH-1:0]  outputs  write enable, address, data to register-bank write port; zero_flag, carry_flag  outputs 1 each; busy  output 1.

Function
REQ-012 Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL A by B[2:0], 110 SHR (logical) A by B[2:0], 111 MUL (low WIDTH bits of A*B).
REQ-013 FSM states: IDLE, MUL, WB; in_ready = 1 only in IDLE; busy = !in_ready.
REQ-014 Acceptance: rising edge with in_valid && in_ready; opcode, rs1_data, rs2_data, rd captured at that edge; later input changes have no effect on the operation.
REQ-015 IDLE -> WB on acceptance of opcodes 000-110, result computed and registered at the accepting edge.
REQ-016 IDLE -> MUL on acceptance of 111; MUL performs shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then -> WB.
REQ-017 WB lasts exactly one cycle, then -> IDLE unconditionally; wb_en = 1 only in WB.
REQ-018 Latency: non-MUL ops wb_en high in cycle 1 after acceptance edge; MUL wb_en high in cycle WIDTH+1; throughput 1 op per 2 cycles (non-MUL).
REQ-019 wb_reg = captured rd and wb_data = result, both stable throughout WB; outside WB they hold last values, wb_en = 0.
REQ-020 in_valid while not in IDLE ignored; no queuing; requester holds in_valid until accepted.
REQ-021 ADD carry_flag = carry out of bit WIDTH-1; SUB carry_flag = 1 iff A < B (unsigned borrow), result wraps modulo 2^WIDTH.
REQ-022 AND/OR/XOR/SHL/SHR carry_flag = 0; shift amount 0 passes A unchanged; bits shifted beyond width discarded.
REQ-023 MUL carry_flag = 1 iff full 2*WIDTH product > 2^WIDTH-1.
REQ-024 zero_flag = 1 iff wb_data == 0; both flags update on entry to WB and hold until next WB.
REQ-025 wb_reg may equal a register being read by a new request; unit makes no forwarding, the bank's write in WB governs.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, wb_en 0, wb_reg 0, wb_data 0, zero_flag 0, carry_flag 0, MUL counter/accumulator 0.
REQ-027 Reset during MUL or WB SHALL abort the operation with no write-back; after rst_n rises, in_ready = 1 in first cycle.

Verification
REQ-028 ADD A=0xF0 B=0x20 rd=2 -> next cycle wb_en=1 wb_reg=2 wb_data=0x10 carry=1 zero=0; following cycle wb_en=0 in_ready=1.
REQ-029 SUB A=0x05 B=0x05 rd=1 -> wb_data=0x00 zero=1 carry=0; SUB A=0x03 B=0x04 -> wb_data=0xFF carry=1.
REQ-030 MUL A=0x12 B=0x10 rd=3 -> in_ready=0 for 9 cycles, wb_en=1 only in cycle 9, wb_data=0x20 carry=1; changing rs1_data mid-MUL has no effect.
REQ-031 SHL A=0x81 B=0x01 -> wb_data=0x02 carry=0; SHR A=0x81 B=0x00 -> wb_data=0x81; in_valid held during WB not accepted until IDLE.
REQ-032 Assert rst_n low at cycle 4 of a MUL -> wb_en never rises, all outputs 0, in_ready=1 in first cycle after release.

Source files
------------

// File: rtl/alu_writeback_unit.sv
// alu_writeback_unit: single-issue ALU with a serial shift-add multiplier.
// Results leave through a one-cycle write-back to the register bank.
//
// state | meaning
// IDLE  | ready to accept a new operation
// MUL   | shift-add multiply, one multiplier bit per cycle
// WB    | one-cycle write-back of result, address and flags
module alu_writeback_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [1:0]       rd,
  output logic             wb_en,
  output logic [1:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 accept;
  logic                 mul_last;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic [2*WIDTH-1:0]   mul_acc_q;
  logic [2*WIDTH-1:0]   mul_mcand_q;
  logic [WIDTH-1:0]     mul_mplier_q;
  logic [CNT_W-1:0]     mul_cnt_q;
  logic [2*WIDTH-1:0]   acc_next;
  logic [1:0]           rd_q;

  assign accept   = in_valid && in_ready;
  // Down-counter reaches terminal count on the last multiplier bit.
  assign mul_last = (mul_cnt_q == CNT_W'(1));
  assign acc_next = mul_mplier_q[0] ? (mul_acc_q + mul_mcand_q) : mul_acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (opcode == OP_MUL) ? S_MUL : S_WB;
      S_MUL:   if (mul_last) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    wb_en    = (state_q == S_WB);
    busy     = (state_q != S_IDLE);
  end

  // Single-cycle operations; MUL is handled by the serial datapath below.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opcode)
      OP_ADD: {alu_carry, alu_res} = {1'b0, rs1_data} + {1'b0, rs2_data};
      OP_SUB: begin
        alu_res   = rs1_data - rs2_data;
        alu_carry = (rs1_data < rs2_data);
      end
      OP_AND:  alu_res = rs1_data & rs2_data;
      OP_OR:   alu_res = rs1_data | rs2_data;
      OP_XOR:  alu_res = rs1_data ^ rs2_data;
      OP_SHL:  alu_res = rs1_data << rs2_data[2:0];
      OP_SHR:  alu_res = rs1_data >> rs2_data[2:0];
      default: alu_res = '0;
    endcase
  end

  // Write-back registers only change on entry to WB so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_reg       <= '0;
      wb_data      <= '0;
      zero_flag    <= 1'b0;
      carry_flag   <= 1'b0;
      rd_q         <= '0;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
    end else if (accept) begin
      rd_q <= rd;
      if (opcode == OP_MUL) begin
        mul_acc_q    <= '0;
        mul_mcand_q  <= {{WIDTH{1'b0}}, rs1_data};
        mul_mplier_q <= rs2_data;
        mul_cnt_q    <= CNT_W'(WIDTH);
      end else begin
        wb_reg     <= rd;
        wb_data    <= alu_res;
        carry_flag <= alu_carry;
        zero_flag  <= (alu_res == '0);
      end
    end else if (state_q == S_MUL) begin
      mul_acc_q    <= acc_next;
      mul_mcand_q  <= mul_mcand_q << 1;
      mul_mplier_q <= mul_mplier_q >> 1;
      mul_cnt_q    <= mul_cnt_q - CNT_W'(1);
      if (mul_last) begin
        wb_reg     <= rd_q;
        wb_data    <= acc_next[WIDTH-1:0];
        carry_flag <= |acc_next[2*WIDTH-1:WIDTH];
        zero_flag  <= (acc_next[WIDTH-1:0] == '0);
      end
    end
  end

endmodule
